expanded_slot_unit: RTL and testbench
=====================================

EXPANDED_SLOT_UNIT -- requirements
Module: expanded_slot_unit

Interface
REQ-001 SHALL provide parameter EXP_MASK, default 4'b1000, one bit per primary slot 0-3; 1 = slot expanded to 4 sub-slots.
REQ-002 SHALL provide parameter PSLOT_PORT, default 8'hA8, I/O port of the primary slot register.
REQ-003 SHALL provide parameters WAIT_PORT, default 8'hA0, and WAIT_PORT_MASK, default 8'hFE; an I/O access matches when (A[7:0] & mask) == (WAIT_PORT & mask).
REQ-004 SHALL provide parameters WAIT_CYCLES, default 58, and HOLDOFF_CYCLES, default 26, both in i_CLK cycles, range 0-127.
REQ-005 i_CLK  in  1  system clock; all state on its rising edge.
REQ-006 i_RST_n  in  1  reset, synchronous, active-low.
REQ-007 i_MERQ / i_IORQ  in  1 each  memory / I/O request qualifiers.
REQ-008 i_RD / i_WR  in  1 each  read / write strobes, level, held for the whole access.
REQ-009 i_A  in  16  CPU address.
REQ-010 i_WDATA  in  8  write data.
REQ-011 i_MEM_BUSY  in  1  OR of downstream memory-unit busy flags.
REQ-012 o_RDATA  out  8  read data, valid when o_RD_OE = 1.
REQ-013 o_RD_OE  out  1  this block drives read data this cycle.
REQ-014 o_SEL  out  64  one-hot memory select, bit index = prim*16 + sub*4 + page.
REQ-015 o_PSLOT  out  8  current primary slot register.
REQ-016 o_BUSY  out  1  CPU wait request.

Function
REQ-017 Primary register: 8 bits, page n slot = bits [2n+1:2n]; written once per access on the first cycle i_IORQ & i_WR & A[7:0]==PSLOT_PORT is seen high after being low (rising-edge detect via registered copy).
REQ-018 Primary read: i_IORQ & i_RD & A[7:0]==PSLOT_PORT -> o_RD_OE=1, o_RDATA = primary register, combinational, same cycle.
REQ-019 Secondary registers: one 8-bit register per primary slot with EXP_MASK bit set; bits [2n+1:2n] = sub-slot for page n; non-expanded slots hold none.
REQ-020 Secondary access: i_MERQ & i_A==16'hFFFF & EXP_MASK[pslot[7:6]]==1 targets secondary register of pslot[7:6].
REQ-021 Secondary write: on rising edge of (secondary access & i_WR), register <= i_WDATA; o_SEL SHALL be all zero for the whole access.
REQ-022 Secondary read: o_RD_OE=1, o_RDATA = bitwise inverse of register, combinational; o_SEL all zero.
REQ-023 FFFFh with page-3 slot not expanded: normal memory access, o_RD_OE=0.
REQ-024 o_SEL decode: when i_MERQ=1 and not a secondary access, page=A[15:14], prim=pslot[2page+1:2page], sub = EXP_MASK[prim] ? secreg[prim][2page+1:2page] : 0; exactly one bit set; otherwise all zero.
REQ-025 Register updates take effect on o_SEL from the cycle after the write edge.
REQ-026 Wait generator states IDLE, WAIT, HOLD.
REQ-027 IDLE -> WAIT on first cycle of matching I/O access (i_IORQ & (i_RD|i_WR) & port match) seen high after low; counter loaded WAIT_CYCLES.
REQ-028 WAIT: counter decrements each cycle; at counter==0 -> HOLD, counter loaded HOLDOFF_CYCLES; WAIT lasts WAIT_CYCLES+1 cycles.
REQ-029 HOLD: counter decrements; at 0 -> IDLE; new matching edges in WAIT/HOLD are ignored, not queued.
REQ-030 o_BUSY = (state==WAIT) | i_MEM_BUSY, combinational OR of a registered state and the input.
REQ-031 Simultaneous primary-port write and memory access cannot occur (IORQ/MERQ exclusive); if both asserted, I/O behaviour applies and o_SEL SHALL be all zero.
REQ-032 Otherwise o_RD_OE=0, o_RDATA=8'h00.

Reset
REQ-033 While i_RST_n=0 at a clock edge: primary register 8'h00, all secondary registers 8'h00, edge-detect flops 0, state IDLE, counter 0.
REQ-034 Reset mid-WAIT SHALL drop o_BUSY (absent i_MEM_BUSY) the cycle after the reset edge.
REQ-035 After reset o_PSLOT=8'h00, o_BUSY=i_MEM_BUSY, o_SEL per decode with slot 0 sub 0.

Verification
REQ-036 Reset, MERQ read A=4000h -> o_SEL bit 1 only; o_PSLOT=00h.
REQ-037 IO write A8h=C0h, write FFFFh=8'b0100_0000 (slot 3), read FFFFh -> o_RDATA=BFh, o_RD_OE=1, o_SEL=0 during both FFFFh accesses; then MERQ A=C000h -> o_SEL bit 3*16+1*4+3=55.
REQ-038 EXP_MASK=0000, A8h=C0h, write FFFFh=55h -> o_SEL bit 51 asserted, o_RD_OE=0, no secondary state change.
REQ-039 IO write port A1h held 5 cycles -> o_BUSY high exactly 59 cycles from first cycle after edge; second A0h access 10 cycles after release of WAIT -> no busy; access after HOLD ends -> busy again.
REQ-040 i_RST_n pulsed at WAIT cycle 20 -> o_BUSY low next cycle, A8h reads 00h.
REQ-041 A8h write held 10 cycles with data changing -> register holds data sampled on first cycle only.

Source files
------------

// File: rtl/expanded_slot_unit.sv
// Expanded slot unit: primary slot register, per-slot secondary (sub-slot)
// registers at FFFFh, 64-way memory select decode and an I/O wait generator.
// Ports:
//   i_CLK, i_RST_n          clock, synchronous active-low reset
//   i_MERQ, i_IORQ          memory / I/O request qualifiers
//   i_RD, i_WR              level read / write strobes
//   i_A[15:0], i_WDATA[7:0] CPU address and write data
//   i_MEM_BUSY              downstream busy OR
//   o_RDATA[7:0], o_RD_OE   read data and its drive enable
//   o_SEL[63:0]             one-hot select, index prim*16+sub*4+page
//   o_PSLOT[7:0]            primary slot register
//   o_BUSY                  CPU wait request
module expanded_slot_unit #(
  parameter logic [3:0] EXP_MASK       = 4'b1000,
  parameter logic [7:0] PSLOT_PORT     = 8'hA8,
  parameter logic [7:0] WAIT_PORT      = 8'hA0,
  parameter logic [7:0] WAIT_PORT_MASK = 8'hFE,
  parameter int unsigned WAIT_CYCLES    = 58,
  parameter int unsigned HOLDOFF_CYCLES = 26
) (
  input  logic        i_CLK,
  input  logic        i_RST_n,
  input  logic        i_MERQ,
  input  logic        i_IORQ,
  input  logic        i_RD,
  input  logic        i_WR,
  input  logic [15:0] i_A,
  input  logic [7:0]  i_WDATA,
  input  logic        i_MEM_BUSY,
  output logic [7:0]  o_RDATA,
  output logic        o_RD_OE,
  output logic [63:0] o_SEL,
  output logic [7:0]  o_PSLOT,
  output logic        o_BUSY
);

  localparam logic [6:0] LP_WAIT = 7'(WAIT_CYCLES);
  localparam logic [6:0] LP_HOLD = 7'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nx;
  logic [6:0] r_cnt;
  logic [6:0] w_cnt_nx;

  logic [7:0] r_pslot;
  logic       r_pwr_d;
  logic       r_swr_d;
  logic       r_wio_d;

  logic [3:0][7:0] w_sec;

  logic       w_mem;
  logic       w_phit;
  logic       w_pwr;
  logic       w_prd;
  logic       w_sec_acc;
  logic       w_swr;
  logic       w_wio;
  logic       w_wio_edge;
  logic [1:0] w_page;
  logic [1:0] w_prim;
  logic [1:0] w_sub;
  logic [7:0] w_sec_prim;
  logic [7:0] w_sec_top;
  logic [5:0] w_idx;

  // I/O wins when both qualifiers are asserted.
  assign w_mem  = i_MERQ & ~i_IORQ;
  assign w_phit = (i_A[7:0] == PSLOT_PORT);
  assign w_pwr  = i_IORQ & i_WR & w_phit;
  assign w_prd  = i_IORQ & i_RD & w_phit;

  assign w_sec_top = w_sec[r_pslot[7:6]];
  assign w_sec_acc = w_mem & (i_A == 16'hFFFF)
                   & EXP_MASK[r_pslot[7:6]];
  assign w_swr = w_sec_acc & i_WR;

  assign w_wio = i_IORQ & (i_RD | i_WR)
               & ((i_A[7:0] & WAIT_PORT_MASK)
                  == (WAIT_PORT & WAIT_PORT_MASK));
  assign w_wio_edge = w_wio & ~r_wio_d;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      r_pslot <= 8'h00;
      r_pwr_d <= 1'b0;
      r_swr_d <= 1'b0;
      r_wio_d <= 1'b0;
    end else begin
      if (w_pwr && !r_pwr_d) r_pslot <= i_WDATA;
      r_pwr_d <= w_pwr;
      r_swr_d <= w_swr;
      r_wio_d <= w_wio;
    end
  end

  // Only expanded slots get a secondary register; others read as zero.
  for (genvar g = 0; g < 4; g++) begin : g_sec
    if (EXP_MASK[g]) begin : g_exp
      logic [7:0] r_sec;
      always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
          r_sec <= 8'h00;
        end else if (w_swr && !r_swr_d
                     && r_pslot[7:6] == 2'(g)) begin
          r_sec <= i_WDATA;
        end
      end
      assign w_sec[g] = r_sec;
    end else begin : g_flat
      assign w_sec[g] = 8'h00;
    end
  end

  assign w_page     = i_A[15:14];
  assign w_prim     = r_pslot[{w_page, 1'b0} +: 2];
  assign w_sec_prim = w_sec[w_prim];
  assign w_sub      = EXP_MASK[w_prim]
                    ? w_sec_prim[{w_page, 1'b0} +: 2]
                    : 2'b00;
  assign w_idx      = {w_prim, w_sub, w_page};

  assign o_SEL = (w_mem && !w_sec_acc)
               ? (64'd1 << w_idx) : 64'd0;

  always_comb begin
    o_RD_OE = 1'b0;
    o_RDATA = 8'h00;
    if (w_prd) begin
      o_RD_OE = 1'b1;
      o_RDATA = r_pslot;
    end else if (w_sec_acc && i_RD) begin
      o_RD_OE = 1'b1;
      o_RDATA = ~w_sec_top;
    end
  end

  assign o_PSLOT = r_pslot;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 7'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Edges arriving in WAIT or HOLD are dropped.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_wio_edge) begin
          w_state_nx = S_WAIT;
          w_cnt_nx   = LP_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 7'd0) begin
          w_state_nx = S_HOLD;
          w_cnt_nx   = LP_HOLD;
        end else begin
          w_cnt_nx = r_cnt - 7'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt == 7'd0) begin
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt - 7'd1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = 7'd0;
      end
    endcase
  end

  assign o_BUSY = (r_state == S_WAIT) | i_MEM_BUSY;

endmodule

// File: tb/tb_expanded_slot_unit.sv
// Testbench for expanded_slot_unit: directed scenarios plus randomized
// traffic checked against a timestamp-based behavioural model.
module tb_expanded_slot_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        merq = 1'b0;
  logic        iorq = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] a = 16'h0;
  logic [7:0]  wdata = 8'h0;
  logic        mem_busy = 1'b0;

  logic [7:0]  s_rdata, s_rdata0;
  logic        s_oe, s_oe0;
  logic [63:0] s_sel, s_sel0;
  logic [7:0]  s_pslot, s_pslot0;
  logic        s_busy, s_busy0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  expanded_slot_unit u_dut (
    .i_CLK(clk), .i_RST_n(rst_n), .i_MERQ(merq), .i_IORQ(iorq),
    .i_RD(rd), .i_WR(wr), .i_A(a), .i_WDATA(wdata),
    .i_MEM_BUSY(mem_busy), .o_RDATA(s_rdata), .o_RD_OE(s_oe),
    .o_SEL(s_sel), .o_PSLOT(s_pslot), .o_BUSY(s_busy)
  );

  expanded_slot_unit #(.EXP_MASK(4'b0000)) u_dut0 (
    .i_CLK(clk), .i_RST_n(rst_n), .i_MERQ(merq), .i_IORQ(iorq),
    .i_RD(rd), .i_WR(wr), .i_A(a), .i_WDATA(wdata),
    .i_MEM_BUSY(mem_busy), .o_RDATA(s_rdata0), .o_RD_OE(s_oe0),
    .o_SEL(s_sel0), .o_PSLOT(s_pslot0), .o_BUSY(s_busy0)
  );

  // Reference model of the default-parameter instance.
  localparam logic [3:0] M_EXP = 4'b1000;
  logic [7:0] m_pslot;
  logic [7:0] m_sec [4];
  bit m_pwr_q, m_swr_q, m_wio_q;
  int cyc = 0;
  int busy_end = 0;
  int free_at = 0;

  function automatic bit m_sec_acc();
    return merq && !iorq && a == 16'hFFFF && M_EXP[m_pslot[7:6]];
  endfunction

  function automatic logic [63:0] m_sel();
    int page, prim, sub, idx;
    if (!merq || iorq || m_sec_acc()) return 64'd0;
    page = int'(a[15:14]);
    prim = int'((m_pslot >> (2 * page)) & 8'h03);
    sub = 0;
    if (M_EXP[prim[1:0]])
      sub = int'((m_sec[prim] >> (2 * page)) & 8'h03);
    idx = 16 * prim + 4 * sub + page;
    return 64'd1 << idx;
  endfunction

  function automatic logic [8:0] m_read();
    if (iorq && rd && a[7:0] == 8'hA8) return {1'b1, m_pslot};
    if (m_sec_acc() && rd) return {1'b1, ~m_sec[m_pslot[7:6]]};
    return 9'h000;
  endfunction

  function automatic bit m_busy();
    return (cyc < busy_end) || mem_busy;
  endfunction

  task automatic model_update();
    bit pwr, swr, wio;
    int s;
    cyc++;
    if (!rst_n) begin
      m_pslot = 8'h00;
      for (int i = 0; i < 4; i++) m_sec[i] = 8'h00;
      m_pwr_q = 0; m_swr_q = 0; m_wio_q = 0;
      busy_end = 0; free_at = 0;
      return;
    end
    pwr = iorq && wr && a[7:0] == 8'hA8;
    swr = m_sec_acc() && wr;
    wio = iorq && (rd || wr) && ((a[7:0] & 8'hFE) == 8'hA0);
    s = int'(m_pslot[7:6]);
    if (swr && !m_swr_q) m_sec[s] = wdata;
    if (pwr && !m_pwr_q) m_pslot = wdata;
    if (wio && !m_wio_q && cyc >= free_at) begin
      busy_end = cyc + 59;
      free_at = cyc + 87;
    end
    m_pwr_q = pwr; m_swr_q = swr; m_wio_q = wio;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    merq = 0; iorq = 0; rd = 0; wr = 0; a = 16'h0; wdata = 8'h0;
  endtask

  task automatic do_reset();
    idle();
    mem_busy = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    #1;
    n_total++;
    if (s_pslot !== 8'h00) $display("FAIL rst_pslot got=%h exp=00", s_pslot);
    else n_pass++;
    n_total++;
    if (s_busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", s_busy);
    else n_pass++;
    mem_busy = 1;
    #1;
    n_total++;
    if (s_busy !== 1'b1) $display("FAIL rst_membusy got=%b exp=1", s_busy);
    else n_pass++;
    mem_busy = 0;
    merq = 1; rd = 1; a = 16'h4000;
    #1;
    n_total++;
    if (s_sel !== 64'd2) $display("FAIL rst_sel4000 got=%h exp=%h", s_sel, 64'd2);
    else n_pass++;
    n_total++;
    if (s_oe !== 1'b0) $display("FAIL rst_oe got=%b exp=0", s_oe);
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_expand();
    do_reset();
    iorq = 1; wr = 1; a = 16'h00A8; wdata = 8'hC0;
    tick();
    idle();
    #1;
    n_total++;
    if (s_pslot !== 8'hC0) $display("FAIL exp_pslot got=%h exp=C0", s_pslot);
    else n_pass++;
    merq = 1; wr = 1; a = 16'hFFFF; wdata = 8'b0100_0000;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_total++;
      if (s_sel !== 64'd0) $display("FAIL exp_wsel got=%h exp=0", s_sel);
      else n_pass++;
      tick();
    end
    idle();
    tick();
    merq = 1; rd = 1; a = 16'hFFFF;
    #1;
    n_total++;
    if (s_rdata !== 8'hBF || s_oe !== 1'b1)
      $display("FAIL exp_secrd got=%h/%b exp=BF/1", s_rdata, s_oe);
    else n_pass++;
    n_total++;
    if (s_sel !== 64'd0) $display("FAIL exp_rsel got=%h exp=0", s_sel);
    else n_pass++;
    tick();
    idle();
    merq = 1; rd = 1; a = 16'hC000;
    #1;
    n_total++;
    if (s_sel !== (64'd1 << 55))
      $display("FAIL exp_selC000 got=%h exp=%h", s_sel, 64'd1 << 55);
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_no_expand();
    do_reset();
    iorq = 1; wr = 1; a = 16'h00A8; wdata = 8'hC0;
    tick();
    idle();
    merq = 1; wr = 1; a = 16'hFFFF; wdata = 8'h55;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_total++;
      if (s_sel0 !== (64'd1 << 51) || s_oe0 !== 1'b0)
        $display("FAIL noexp_wr got=%h/%b exp=%h/0", s_sel0, s_oe0, 64'd1 << 51);
      else n_pass++;
      tick();
    end
    idle();
    merq = 1; rd = 1; a = 16'hFFFF;
    #1;
    n_total++;
    if (s_sel0 !== (64'd1 << 51) || s_oe0 !== 1'b0 || s_rdata0 !== 8'h00)
      $display("FAIL noexp_rd got=%h/%b/%h exp=%h/0/00",
               s_sel0, s_oe0, s_rdata0, 64'd1 << 51);
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_wait();
    bit tr [160];
    int c_a, c_b, c_c;
    do_reset();
    for (int k = 0; k < 160; k++) begin
      idle();
      if (k < 5) begin
        iorq = 1; wr = 1; a = 16'h00A1; wdata = 8'h11;
      end else if (k >= 69 && k < 72) begin
        iorq = 1; rd = 1; a = 16'h00A0;
      end else if (k >= 95 && k < 98) begin
        iorq = 1; wr = 1; a = 16'h00A0;
      end
      #1;
      tr[k] = s_busy;
      n_total++;
      if (s_busy !== m_busy())
        $display("FAIL wait_busy k=%0d got=%b exp=%b", k, s_busy, m_busy());
      else n_pass++;
      tick();
    end
    idle();
    c_a = 0; c_b = 0; c_c = 0;
    for (int k = 0; k < 96; k++) if (tr[k]) c_a++;
    for (int k = 1; k < 60; k++) if (tr[k]) c_b++;
    for (int k = 96; k < 160; k++) if (tr[k]) c_c++;
    n_total++;
    if (c_a !== 59) $display("FAIL wait_len got=%0d exp=59", c_a);
    else n_pass++;
    n_total++;
    if (c_b !== 59) $display("FAIL wait_pos got=%0d exp=59", c_b);
    else n_pass++;
    n_total++;
    if (tr[96] !== 1'b1 || c_c !== 59)
      $display("FAIL wait_again got=%b/%0d exp=1/59", tr[96], c_c);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    iorq = 1; wr = 1; a = 16'h00A8; wdata = 8'h5A;
    tick();
    idle();
    iorq = 1; rd = 1; a = 16'h00A0;
    tick();
    idle();
    for (int k = 0; k < 19; k++) tick();
    #1;
    n_total++;
    if (s_busy !== 1'b1) $display("FAIL mid_busy got=%b exp=1", s_busy);
    else n_pass++;
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    n_total++;
    if (s_busy !== 1'b0) $display("FAIL mid_drop got=%b exp=0", s_busy);
    else n_pass++;
    iorq = 1; rd = 1; a = 16'h00A8;
    #1;
    n_total++;
    if (s_rdata !== 8'h00 || s_oe !== 1'b1)
      $display("FAIL mid_rdA8 got=%h/%b exp=00/1", s_rdata, s_oe);
    else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_hold_write();
    do_reset();
    iorq = 1; wr = 1; a = 16'h00A8; wdata = 8'h3C;
    for (int k = 0; k < 10; k++) begin
      tick();
      wdata = 8'(($urandom_range(1, 255) + 8'h3C));
      #1;
      n_total++;
      if (s_pslot !== 8'h3C || s_pslot !== m_pslot)
        $display("FAIL hold_wr k=%0d got=%h exp=3C", k, s_pslot);
      else n_pass++;
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    int kind, hold;
    logic [8:0] rexp;
    do_reset();
    for (int op = 0; op < 400; op++) begin
      idle();
      kind = int'($urandom_range(0, 7));
      case (kind)
        1: begin merq = 1; rd = 1; a = 16'($urandom); end
        2: begin merq = 1; wr = 1; a = 16'($urandom); wdata = 8'($urandom); end
        3: begin merq = 1; rd = 1; a = 16'hFFFF; end
        4: begin merq = 1; wr = 1; a = 16'hFFFF; wdata = 8'($urandom); end
        5: begin
          iorq = 1; wr = 1; a = {8'($urandom), 8'hA8};
          wdata = 8'($urandom);
          if ($urandom_range(0, 1) == 1) wdata[7:6] = 2'b11;
        end
        6: begin iorq = 1; rd = 1; a = {8'($urandom), 8'hA8}; end
        7: begin
          iorq = 1;
          if ($urandom_range(0, 1) == 1) rd = 1; else wr = 1;
          a = {8'($urandom), 8'hA0 | 8'($urandom_range(0, 3))};
          wdata = 8'($urandom);
        end
        default: ;
      endcase
      hold = int'($urandom_range(1, 4));
      for (int h = 0; h < hold; h++) begin
        mem_busy = ($urandom_range(0, 7) == 0);
        #1;
        rexp = m_read();
        n_total++;
        if (s_sel !== m_sel())
          $display("FAIL rnd_sel op=%0d got=%h exp=%h", op, s_sel, m_sel());
        else n_pass++;
        n_total++;
        if (s_oe !== rexp[8] || s_rdata !== rexp[7:0])
          $display("FAIL rnd_rd op=%0d got=%b/%h exp=%b/%h",
                   op, s_oe, s_rdata, rexp[8], rexp[7:0]);
        else n_pass++;
        n_total++;
        if (s_busy !== m_busy())
          $display("FAIL rnd_busy op=%0d got=%b exp=%b", op, s_busy, m_busy());
        else n_pass++;
        n_total++;
        if (s_pslot !== m_pslot)
          $display("FAIL rnd_pslot op=%0d got=%h exp=%h", op, s_pslot, m_pslot);
        else n_pass++;
        tick();
      end
      if ($urandom_range(0, 1) == 1) begin
        idle();
        tick();
      end
    end
    idle();
    mem_busy = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_expand();
    test_no_expand();
    test_wait();
    test_reset_mid_wait();
    test_hold_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
